// File: rtl/apb5_requester.sv
// APB5 requester: turns a valid/ready command into one APB5 transfer and
// returns a valid/ready response, aborting with a timeout if pready never rises.
module apb5_requester #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic                    pclk,
  input  logic                    presetn,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_strb,
  input  logic [2:0]              cmd_prot,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_slverr,
  output logic                    rsp_timeout,
  output logic [ADDR_WIDTH-1:0]   paddr,
  output logic [2:0]              pprot,
  output logic                    pselx,
  output logic                    penable,
  output logic                    pwrite,
  output logic [DATA_WIDTH-1:0]   pwdata,
  output logic [DATA_WIDTH/8-1:0] pstrb,
  input  logic                    pready,
  input  logic [DATA_WIDTH-1:0]   prdata,
  input  logic                    pslverr,
  output logic                    pwakeup
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  localparam logic [7:0] TMO = 8'(TIMEOUT);

  state_t     state;
  logic [7:0] wait_cnt;

  // All outputs are registered; each transition sets the values seen in the
  // destination state, so cmd_ready reads 1 only once IDLE has been entered.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      cmd_ready   <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_slverr  <= 1'b0;
      rsp_timeout <= 1'b0;
      paddr       <= '0;
      pprot       <= '0;
      pselx       <= 1'b0;
      penable     <= 1'b0;
      pwrite      <= 1'b0;
      pwdata      <= '0;
      pstrb       <= '0;
      pwakeup     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          cmd_ready <= 1'b1;
          pwakeup   <= cmd_valid;
          if (cmd_valid && cmd_ready) begin
            state     <= SETUP;
            cmd_ready <= 1'b0;
            pwakeup   <= 1'b1;
            pselx     <= 1'b1;
            penable   <= 1'b0;
            paddr     <= cmd_addr;
            pprot     <= cmd_prot;
            pwrite    <= cmd_write;
            pwdata    <= cmd_write ? cmd_wdata : '0;
            pstrb     <= cmd_write ? cmd_strb  : '0;
            wait_cnt  <= '0;
          end
        end

        SETUP: begin
          state   <= ACCESS;
          penable <= 1'b1;
        end

        ACCESS: begin
          // pready wins over an expiring counter in the same cycle
          if (pready) begin
            state       <= RESP;
            pselx       <= 1'b0;
            penable     <= 1'b0;
            rsp_valid   <= 1'b1;
            rsp_rdata   <= pwrite ? '0 : prdata;
            rsp_slverr  <= pslverr;
            rsp_timeout <= 1'b0;
          end else if (wait_cnt == TMO) begin
            state       <= RESP;
            pselx       <= 1'b0;
            penable     <= 1'b0;
            rsp_valid   <= 1'b1;
            rsp_rdata   <= '0;
            rsp_slverr  <= 1'b1;
            rsp_timeout <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end

        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            pwakeup   <= cmd_valid;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
